// File: rtl/add_serial_arb.sv
// Round-robin arbiter in front of a shared bit-serial adder: one winner per
// operation, the result is delivered 8 ADD cycles later as a one-hot strobe.
module add_serial_arb #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_sum,
  output logic              resp_cout,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [NREQ-1:0] LSB_ONE  = NREQ'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);
  localparam logic [IW-1:0]   PTR_RST  = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sh;
  logic            r_carry;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_valid;
  logic [W-1:0]    r_sum;
  logic            r_cout;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_cand;
  logic            w_sbit;
  logic            w_cnext;
  logic [W-1:0]    w_sh_next;

  // Round-robin search upward from ptr+1; NREQ is a power of two, so the
  // candidate index wraps naturally in IW bits.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = r_ptr + IW'(k);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end else begin
        w_win   = w_win;
      end
    end
  end

  assign w_sbit    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cnext   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_sh_next = {w_sbit, r_sh[W-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next = S_ADD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ADD: begin
        if (r_cnt == CNT_LAST) begin
          w_next = S_DONE;
        end else begin
          w_next = S_ADD;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, serial add, result and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= PTR_RST;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_carry <= 1'b0;
      r_gnt   <= '0;
      r_valid <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_gnt   <= '0;
      r_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx   <= w_win;
            r_a     <= a_in[int'(w_win)*W +: W];
            r_b     <= b_in[int'(w_win)*W +: W];
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_gnt   <= LSB_ONE << w_win;
          end
        end
        S_ADD: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cnext;
          r_sh    <= w_sh_next;
          // Last bit: publish the completed result so it is visible in DONE.
          if (r_cnt == CNT_LAST) begin
            r_valid <= LSB_ONE << r_idx;
            r_sum   <= w_sh_next;
            r_cout  <= w_cnext;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_ptr <= r_idx;
        end
        default: begin
          r_ptr <= r_ptr;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign resp_valid = r_valid;
  assign resp_sum   = r_sum;
  assign resp_cout  = r_cout;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_add_serial_arb.sv
// Bench for add_serial_arb: transaction-level model compared every cycle plus
// directed scenarios with hand-computed results.
module tb_add_serial_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'd0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic [3:0]  gnt;
  logic [3:0]  resp_valid;
  logic [7:0]  resp_sum;
  logic        resp_cout;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;
  bit chk_en   = 1'b0;

  add_serial_arb #(.NREQ(4), .W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .resp_valid(resp_valid), .resp_sum(resp_sum),
    .resp_cout(resp_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      int idx = (ptr + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [8:0] add_of(input logic [31:0] a, input logic [31:0] b, input int i);
    logic [31:0] sa = a >> (8 * i);
    logic [31:0] sb = b >> (8 * i);
    return {1'b0, sa[7:0]} + {1'b0, sb[7:0]};
  endfunction

  // Model: phase counts cycles since the grant edge (0 = idle, 1 = grant
  // cycle, 9 = result cycle).
  int         m_phase = 0;
  int         m_ptr   = 3;
  int         m_win   = 0;
  logic [8:0] m_res   = 9'd0;
  logic [7:0] m_sum   = 8'd0;
  logic       m_cout  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_ptr <= 3; m_win <= 0; m_res <= 9'd0; m_sum <= 8'd0; m_cout <= 1'b0;
    end else if (m_phase == 0) begin
      if (rr_pick(req, m_ptr) >= 0) begin
        m_win   <= rr_pick(req, m_ptr);
        m_res   <= add_of(a_in, b_in, rr_pick(req, m_ptr));
        m_phase <= 1;
      end
    end else if (m_phase == 8) begin
      m_sum   <= m_res[7:0];
      m_cout  <= m_res[8];
      m_phase <= 9;
    end else if (m_phase == 9) begin
      m_phase <= 0;
      m_ptr   <= m_win;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  logic [3:0] e_gnt, e_valid;
  assign e_gnt   = (m_phase == 1) ? (4'b0001 << m_win) : 4'b0000;
  assign e_valid = (m_phase == 9) ? (4'b0001 << m_win) : 4'b0000;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_gnt",   32'(gnt),        32'(e_gnt));
      chk("cyc_valid", 32'(resp_valid), 32'(e_valid));
      chk("cyc_sum",   32'(resp_sum),   32'(m_sum));
      chk("cyc_cout",  32'(resp_cout),  32'(m_cout));
      chk("cyc_busy",  32'(busy),       32'(m_phase != 0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    cyc_no++;
  endtask

  initial begin
    int last_t;
    int n;
    bit found;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt",   32'(gnt),        32'h0);
    chk("rst_valid", 32'(resp_valid), 32'h0);
    chk("rst_sum",   32'(resp_sum),   32'h0);
    chk("rst_cout",  32'(resp_cout),  32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    chk_en = 1'b1;
    rst = 1'b0;
    cyc();

    // Requester 0: 0x5A + 0x33.
    req = 4'b0001; a_in[7:0] = 8'h5A; b_in[7:0] = 8'h33;
    cyc();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    repeat (7) cyc();
    chk("t1_valid_early", 32'(resp_valid), 32'h0);
    cyc();
    chk("t1_valid", 32'(resp_valid), 32'h1);
    chk("t1_sum", 32'(resp_sum), 32'h8D);
    chk("t1_cout", 32'(resp_cout), 32'h0);
    cyc();
    chk("t1_busy_end", 32'(busy), 32'h0);
    chk("t1_sum_hold", 32'(resp_sum), 32'h8D);

    // Requester 2: 0xFF + 0x01 wraps with carry.
    req = 4'b0100; a_in[23:16] = 8'hFF; b_in[23:16] = 8'h01;
    cyc();
    chk("t2_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    repeat (8) cyc();
    chk("t2_valid", 32'(resp_valid), 32'h4);
    chk("t2_sum", 32'(resp_sum), 32'h00);
    chk("t2_cout", 32'(resp_cout), 32'h1);
    cyc();

    // Requester 3: 0x80 + 0x80.
    req = 4'b1000; a_in[31:24] = 8'h80; b_in[31:24] = 8'h80;
    cyc();
    chk("t2b_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    repeat (8) cyc();
    chk("t2b_valid", 32'(resp_valid), 32'h8);
    chk("t2b_sum", 32'(resp_sum), 32'h00);
    chk("t2b_cout", 32'(resp_cout), 32'h1);
    cyc();

    // All four requesting: order 0,1,2,3, grants 10 cycles apart.
    a_in = 32'h33_23_13_03; b_in = 32'h24_23_22_21;
    req = 4'b1111;
    last_t = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0; found = 1'b0;
      while (n < 15 && !found) begin
        cyc(); n++;
        if (gnt != 4'd0) found = 1'b1;
      end
      if (!found) begin
        chk("t3_gnt_timeout", 32'(k), 32'hFFFF_FFFF);
      end else begin
        chk("t3_order", 32'(gnt), 32'(4'b0001 << k));
        if (k > 0) chk("t3_spacing", 32'(cyc_no - last_t), 32'd10);
        last_t = cyc_no;
      end
      req[k] = 1'b0;
    end
    repeat (9) cyc();

    // After requester 1 is served, 0101 must go to 2 before 0.
    req = 4'b0010; a_in[15:8] = 8'h40; b_in[15:8] = 8'h02;
    cyc();
    chk("t4_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    repeat (9) cyc();
    req = 4'b0101;
    cyc();
    chk("t4_gnt2", 32'(gnt), 32'h4);
    req = 4'b0001;
    repeat (9) cyc();
    chk("t4_gap", 32'(gnt), 32'h0);
    cyc();
    chk("t4_gnt0", 32'(gnt), 32'h1);
    req = 4'b0000;
    repeat (9) cyc();

    // Inputs disturbed during ADD must not change the result or re-grant.
    req = 4'b0001; a_in = 32'h0000_00C7; b_in = 32'h0000_005E;
    cyc();
    chk("t5_gnt", 32'(gnt), 32'h1);
    for (int j = 0; j < 8; j++) begin
      req = j[0] ? 4'b1111 : 4'b0000;
      a_in = $urandom; b_in = $urandom;
      cyc();
      chk("t5_no_gnt", 32'(gnt), 32'h0);
      chk("t5_busy", 32'(busy), 32'h1);
    end
    req = 4'b0000;
    chk("t5_valid", 32'(resp_valid), 32'h1);
    chk("t5_sum", 32'(resp_sum), 32'h25);
    chk("t5_cout", 32'(resp_cout), 32'h1);
    cyc();
    chk("t5_idle", 32'(busy), 32'h0);

    // Reset at count 4 aborts the operation.
    req = 4'b0001; a_in = 32'h0000_0011; b_in = 32'h0000_0022;
    cyc();
    chk("t6_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    repeat (4) cyc();
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_sum", 32'(resp_sum), 32'h0);
    chk("t6_rst_cout", 32'(resp_cout), 32'h0);
    chk("t6_rst_valid", 32'(resp_valid), 32'h0);
    cyc();
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cyc();
      chk("t6_no_valid", 32'(resp_valid), 32'h0);
    end
    req = 4'b1010;
    cyc();
    chk("t6_gnt_after", 32'(gnt), 32'h2);
    req = 4'b0000;
    repeat (9) cyc();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
